// File: rtl/aurora_ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aurora_ddr_pkg
// Description : Shared widths and the packed-word type for the Aurora-to-DDR
//               write packer.
// Revision    : 1.0 - initial release
// ============================================================================
package aurora_ddr_pkg;

    localparam int AURORA_DATA_W = 64;
    localparam int DDR_DATA_W    = 512;
    localparam int PACK_LANES    = 8;
    localparam int BEAT_BYTES    = 64;
    localparam int LANE_CNT_W    = $clog2(PACK_LANES);

    typedef struct packed {
        logic [PACK_LANES-1:0] mask;
        logic [DDR_DATA_W-1:0] data;
    } pack_word_t;

    // Mask with the low n_lanes bits set; n_lanes == PACK_LANES yields all ones
    // because the shifted one falls off the top of the vector.
    function automatic logic [PACK_LANES-1:0] lane_mask(input logic [LANE_CNT_W:0] n_lanes);
        logic [PACK_LANES-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (one << n_lanes) - one;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pack_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pack_word_fifo
// Description : First-word-fall-through FIFO of packed 520-bit words with a
//               synchronous clear. A push into a full FIFO is accepted only
//               when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pack_word_fifo
    import aurora_ddr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  pack_word_t push_word,
    input  logic       pop,
    output pack_word_t pop_word,
    output logic       full,
    output logic       empty
);

    localparam int                c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH   = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]  c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

    pack_word_t         r_mem [DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic [c_PTR_W:0]   w_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign full      = (w_count == c_DEPTH);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_pop  = pop && !empty && !clear;
    assign w_do_push = push && (!full || w_do_pop) && !clear;
    assign pop_word  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage is not reset; the consumer masks the head word while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_word;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aurora_ddr_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : aurora_ddr_wr_packer
// Description : Packs the 64-bit Aurora receive stream into 512-bit DDR write
//               beats with byte addresses, flush, clear and beat/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_ddr_wr_packer
    import aurora_ddr_pkg::*;
#(
    parameter logic [31:0] DDR_BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] DDR_ADDR_LIMIT = 32'h4000_0000,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic                     aurora_log_clk_0,
    input  logic                     aurora_rst_0,
    input  logic                     aurora_rxen_i,
    input  logic [AURORA_DATA_W-1:0] aurora_rxdata_i,
    input  logic                     xdma_vin_mem_clear_i,
    input  logic                     flush_i,
    output logic                     ddr_wr_en_o,
    input  logic                     ddr_wr_ready_i,
    output logic [31:0]              ddr_wr_addr_o,
    output logic [DDR_DATA_W-1:0]    ddr_wr_data_o,
    output logic [PACK_LANES-1:0]    ddr_wr_mask_o,
    output logic [31:0]              wr_beat_cnt_o,
    output logic [31:0]              pack_overflow_cnt_o
);

    localparam logic [32:0] c_BEAT_INC = 33'(BEAT_BYTES);
    localparam logic [32:0] c_LIMIT    = {1'b0, DDR_ADDR_LIMIT};

    logic [LANE_CNT_W-1:0]  r_lane_cnt;
    logic [DDR_DATA_W-1:0]  r_word_data;
    logic [31:0]            r_addr;
    logic [31:0]            r_beat_cnt;
    logic [31:0]            r_ovf_cnt;

    logic [LANE_CNT_W:0]    w_lane_after;
    logic [DDR_DATA_W-1:0]  w_word_data;
    logic                   w_clear;
    logic                   w_flush_take;
    logic                   w_emit;
    logic                   w_pop;
    logic                   w_drop;
    logic [32:0]            w_addr_inc;
    pack_word_t             w_push_word;
    pack_word_t             w_head_word;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

    assign w_clear      = xdma_vin_mem_clear_i;
    assign w_lane_after = {1'b0, r_lane_cnt} + {{LANE_CNT_W{1'b0}}, aurora_rxen_i};

    // Current word including this cycle's sample, so a flush sees it too.
    always_comb begin
        w_word_data = r_word_data;
        if (aurora_rxen_i) begin
            w_word_data[{r_lane_cnt, 6'd0} +: AURORA_DATA_W] = aurora_rxdata_i;
        end
    end

    // A full word (lane count reaches PACK_LANES) always emits; a flush only
    // adds an emit for a non-empty partial word.
    assign w_flush_take     = flush_i && (w_lane_after != '0);
    assign w_emit           = !w_clear && (w_lane_after[LANE_CNT_W] || w_flush_take);
    assign w_pop            = !w_fifo_empty && ddr_wr_ready_i && !w_clear;
    assign w_drop           = w_emit && w_fifo_full && !w_pop;
    assign w_push_word.mask = lane_mask(w_lane_after);
    assign w_push_word.data = w_word_data;

    pack_word_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (aurora_log_clk_0),
        .rst        (aurora_rst_0),
        .clear      (w_clear),
        .push       (w_emit),
        .push_word  (w_push_word),
        .pop        (w_pop),
        .pop_word   (w_head_word),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty)
    );

    always_ff @(posedge aurora_log_clk_0 or posedge aurora_rst_0) begin
        if (aurora_rst_0) begin
            r_lane_cnt  <= '0;
            r_word_data <= '0;
        end else if (w_clear || w_emit) begin
            r_lane_cnt  <= '0;
            r_word_data <= '0;
        end else if (aurora_rxen_i) begin
            r_lane_cnt  <= w_lane_after[LANE_CNT_W-1:0];
            r_word_data <= w_word_data;
        end
    end

    assign w_addr_inc = {1'b0, r_addr} + c_BEAT_INC;

    always_ff @(posedge aurora_log_clk_0 or posedge aurora_rst_0) begin
        if (aurora_rst_0) begin
            r_addr     <= DDR_BASE_ADDR;
            r_beat_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else if (w_clear) begin
            r_addr     <= DDR_BASE_ADDR;
            r_beat_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
                r_addr     <= (w_addr_inc >= c_LIMIT) ? DDR_BASE_ADDR : w_addr_inc[31:0];
            end
            if (w_drop && (r_ovf_cnt != 32'hFFFF_FFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 32'd1;
            end
        end
    end

    // Head word is masked to zero while empty so outputs track reset at once.
    assign ddr_wr_en_o         = !w_fifo_empty;
    assign ddr_wr_data_o       = w_fifo_empty ? '0 : w_head_word.data;
    assign ddr_wr_mask_o       = w_fifo_empty ? '0 : w_head_word.mask;
    assign ddr_wr_addr_o       = r_addr;
    assign wr_beat_cnt_o       = r_beat_cnt;
    assign pack_overflow_cnt_o = r_ovf_cnt;

endmodule
`default_nettype wire

// File: doc/aurora_ddr_wr_packer.md
# aurora_ddr_wr_packer

Packs the 64-bit `aurora_rxen`/`aurora_rxdata` stream from `aurora_rx_data_process` into 512-bit DDR write beats with addresses. It sits directly downstream of that block, in the `aurora_log_clk_0` domain. A small FIFO absorbs DDR backpressure, and the upstream stream itself cannot be stalled. The block honours `xdma_vin_mem_clear`, supports a flush of partially filled words, and reports beat and overflow counts.

## Interface
- `DDR_BASE_ADDR`, 32'h0000_0000: byte address of the first beat.
- `DDR_ADDR_LIMIT`, 32'h4000_0000: exclusive byte address at which the write address wraps back to base.
- `FIFO_DEPTH`, 4: number of completed 512-bit words buffered; must be a power of 2 and at least 2.

Ports:
- `aurora_log_clk_0` in 1: sole clock.
- `aurora_rst_0` in 1: reset, asynchronous and active-high.
- `aurora_rxen_i` in 1: input sample valid.
- `aurora_rxdata_i` in 64: input sample.
- `xdma_vin_mem_clear_i` in 1: synchronous clear, level-sensitive.
- `flush_i` in 1: pulse that emits the current partial word.
- `ddr_wr_en_o` out 1: beat valid.
- `ddr_wr_ready_i` in 1: DDR side accepts the beat.
- `ddr_wr_addr_o` out 32: byte address of the beat.
- `ddr_wr_data_o` out 512: beat data.
- `ddr_wr_mask_o` out 8: valid 64-bit lanes, bit i = lane i.
- `wr_beat_cnt_o` out 32: accepted beats; wraps modulo 2^32.
- `pack_overflow_cnt_o` out 32: words dropped because the FIFO was full; saturates at 32'hFFFF_FFFF.

## Operation
- **Lane counter** `lane_cnt` counts 0..7.
  - Each cycle with `aurora_rxen_i`=1 writes `aurora_rxdata_i` into lane `lane_cnt`, i.e. bits [64*lane_cnt+63 : 64*lane_cnt].
  - The first sample therefore lands in bits [63:0].
- **Word completion**: a sample written at `lane_cnt`=7 completes a word.
  - The word is pushed to the FIFO with mask 8'hFF, and `lane_cnt` returns to 0.
- **Flush** (`flush_i`=1 with `lane_cnt`>0 after that cycle's sample):
  - Pushes the partial word with mask = (1<<lane_cnt)-1.
  - Unwritten lanes are zero, and `lane_cnt` returns to 0.
  - `flush_i` with `lane_cnt`=0 is a no-op.
  - If `flush_i` and the 8th sample fall in the same cycle, exactly one full word is pushed.
- **Push rule**: a push succeeds if FIFO occupancy < `FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the word is dropped, `pack_overflow_cnt_o` increments, and `lane_cnt` still resets to 0.
- **Output**: the FIFO is first-word-fall-through, and `ddr_wr_en_o` = FIFO not empty.
  - A beat is accepted when `ddr_wr_en_o` && `ddr_wr_ready_i`; that pops the FIFO.
  - On acceptance, `wr_beat_cnt_o` increments by 1.
  - On acceptance, the address register advances by 64. If the result is ≥ `DDR_ADDR_LIMIT`, it loads `DDR_BASE_ADDR`.
- **Clear** (`xdma_vin_mem_clear_i`=1) has highest priority and acts synchronously. It:
  - resets `lane_cnt` to 0;
  - empties the FIFO;
  - sets the address to `DDR_BASE_ADDR`;
  - zeroes both counters;
  - discards a same-cycle sample, flush or acceptance.
  - While clear is high, `ddr_wr_en_o` is 0 from the next cycle onward.

## Timing
- **Reset values**:
  - `ddr_wr_en_o`=0, `ddr_wr_data_o`=0, `ddr_wr_mask_o`=0.
  - `ddr_wr_addr_o`=`DDR_BASE_ADDR`.
  - `wr_beat_cnt_o`=0, `pack_overflow_cnt_o`=0, `lane_cnt`=0, FIFO empty.
- **Latency**: with the 8th sample sampled at edge N and the FIFO empty, `ddr_wr_en_o` is high after edge N.
  - The beat can therefore be accepted at edge N+1.
- **Stability**: while `ddr_wr_en_o`=1 and `ddr_wr_ready_i`=0, data, mask and address hold stable.
- **Throughput**: one beat per cycle; sustained input needs ready for at least 1 cycle in 8.
- **Counter timing**: both counters update on the edge of the triggering event and are visible the cycle after.
- **Mid-operation reset**: asserting `aurora_rst_0` drops all outputs to their reset values immediately, without waiting for a clock edge.
  - Deassertion is synchronised externally.

## Structure
- **Package `aurora_ddr_pkg`** holds:
  - `AURORA_DATA_W`=64, `DDR_DATA_W`=512, `PACK_LANES`=8, `BEAT_BYTES`=64;
  - the packed-word type {mask[7:0], data[511:0]}.
- **Sub-module `pack_word_fifo`**: a synchronous first-word-fall-through FIFO, 520 bits wide and `FIFO_DEPTH` deep.
  - Ports: push, pop, full, empty, and a clear input.
- Lane packing, flush, address, counters and clear handling stay in the top module.

## Test plan
- **Back-to-back packing**: 16 samples with data 1..16, ready=1.
  - Beat 0: lane0=1 … lane7=8, mask 8'hFF, address = base.
  - Beat 1: lanes 9..16, address = base+64.
  - `wr_beat_cnt_o`=2.
- **Partial flush**: 3 samples (A, B, C), then `flush_i`.
  - One beat: mask 8'h07, lanes 0..2 = A, B, C, lanes 3..7 = 0.
- **Backpressure and overflow**: ready=0, 40 samples.
  - Four beats are held and `pack_overflow_cnt_o`=1.
  - Then ready=1: beats emerge holding words 1..4 in order, addresses base..base+192.
- **Clear mid-word**: 5 samples, clear for 1 cycle, then 8 samples 100..107.
  - Beat lane0=100, address = base, counters restarted.
  - No beat contains pre-clear data.
- **Address wrap**: `DDR_ADDR_LIMIT`=`DDR_BASE_ADDR`+128, 3 full words.
  - Addresses are base, base+64, base.
- **Asynchronous reset**: assert `aurora_rst_0` between edges while `ddr_wr_en_o`=1 and ready=0.
  - `ddr_wr_en_o` falls immediately and all outputs take their reset values.
